// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier for the MUL* ops.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [4:0]  alu_op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg1_q, neg1_d, neg2_q, neg2_d;
  logic        raw_q, raw_d;
  logic [31:0] mag2_q, mag2_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  // Capture-side decode
  logic [2:0]  f3;
  logic        is_m, is_div, sgn1, sgn2, in_neg1, in_neg2, div_zero, div_ovf;
  logic [31:0] in_mag1, in_mag2;

  always_comb begin
    f3       = alu_op[2:0];
    is_m     = (alu_op[4:3] == 2'b01);
    is_div   = f3[2];
    sgn1     = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    sgn2     = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    in_neg1  = sgn1 & data1[31];
    in_neg2  = sgn2 & data2[31];
    in_mag1  = in_neg1 ? -data1 : data1;
    in_mag2  = in_neg2 ? -data2 : data2;
    div_zero = is_div && (data2 == 32'h0);
    div_ovf  = is_div && !f3[0] && (data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_a, fast_b, fast_prod;

  always_comb begin
    fast_a    = {{32{sgn1 & data1[31]}}, data1};
    fast_b    = {{32{sgn2 & data2[31]}}, data2};
    fast_prod = fast_a * fast_b;
  end
`endif

  // One iteration step; acc holds {upper, multiplier} or {remainder, dividend/quotient}
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mag2_q : 32'h0)};
    mul_next  = {mul_sum, acc_q[31:1]};
    div_trial = {acc_q[63:32], acc_q[31]} - {1'b0, mag2_q};
    div_next  = div_trial[32] ? {acc_q[62:0], 1'b0} : {div_trial[31:0], acc_q[30:0], 1'b1};
  end

  // Sign correction and output select
  logic [63:0] prod_fix, corr;
  logic [31:0] quot_fix, rem_fix, fix_out;

  always_comb begin
    prod_fix = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    quot_fix = (neg1_q ^ neg2_q) ? -acc_q[31:0] : acc_q[31:0];
    rem_fix  = neg1_q ? -acc_q[63:32] : acc_q[63:32];
    if (raw_q) begin
      corr = acc_q;
    end else if (op_q[2]) begin
      corr = {rem_fix, quot_fix};
    end else begin
      corr = prod_fix;
    end
    fix_out = ((op_q == 3'b000) || (op_q[2:1] == 2'b10)) ? corr[31:0] : corr[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    raw_d    = raw_q;
    mag2_d   = mag2_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && is_m) begin
            op_d   = f3;
            neg1_d = in_neg1;
            neg2_d = in_neg2;
            mag2_d = in_mag2;
            acc_d  = {32'h0, in_mag1};
            cnt_d  = 5'd0;
            raw_d  = 1'b0;
            if (div_zero) begin
              // Remainder is the raw dividend, so bypass sign correction
              raw_d   = 1'b1;
              acc_d   = {data1, 32'hFFFF_FFFF};
              state_d = StFix;
            end else if (div_ovf) begin
              raw_d   = 1'b1;
              acc_d   = {32'h0, 32'h8000_0000};
              state_d = StFix;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div) begin
              raw_d   = 1'b1;
              acc_d   = fast_prod;
              state_d = StFix;
`endif
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StFix;
          end
        end
        StFix: begin
          result_d = fix_out;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      raw_q    <= 1'b0;
      mag2_q   <= 32'h0;
      acc_q    <= 64'h0;
      result_q <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      raw_q    <= raw_d;
      mag2_q   <= mag2_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q != StIdle);
  assign done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit; expected results are queued at launch.
module tb_muldiv_unit;

  localparam logic [4:0] OpMul    = 5'b01000;
  localparam logic [4:0] OpMulh   = 5'b01001;
  localparam logic [4:0] OpMulhsu = 5'b01010;
  localparam logic [4:0] OpMulhu  = 5'b01011;
  localparam logic [4:0] OpDiv    = 5'b01100;
  localparam logic [4:0] OpDivu   = 5'b01101;
  localparam logic [4:0] OpRem    = 5'b01110;
  localparam logic [4:0] OpRemu   = 5'b01111;
  localparam logic [4:0] OpLui    = 5'b11000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  logic        clock = 1'b0;
  logic        reset, flush, start;
  logic [4:0]  alu_op;
  logic [31:0] data1, data2, result;
  logic        busy, done;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'h0;

  muldiv_unit dut (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .start  (start),
    .alu_op (alu_op),
    .data1  (data1),
    .data2  (data2),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a request through its capture edge; caller sits in the cycle it should be sampled.
  task automatic launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    start  = 1'b1;
    alu_op = op;
    data1  = a;
    data2  = b;
    @(posedge clock);
    #1;
    start  = 1'b0;
    alu_op = 5'd0;
    data1  = $urandom;
    data2  = $urandom;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int          n = 0;
    bit          got = 1'b0;
    logic [31:0] e;
    while (!got && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, {63'd0, got}, 64'd1);
    if (got) begin
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
      check({tag, "_result"}, {32'd0, result}, {32'd0, e});
      last_res = e;
    end
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    @(negedge clock);
    exp_q.push_back(exp);
    launch(op, a, b, tag);
    wait_done(tag, lat);
  endtask

  task automatic quiet_window(input string tag, input int cycles, input bit want_idle);
    int dones = 0;
    int busys = 0;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busys++;
    end
    check({tag, "_no_done"}, 64'(dones), 64'd0);
    if (want_idle) check({tag, "_no_busy"}, 64'(busys), 64'd0);
    check({tag, "_result_held"}, {32'd0, result}, {32'd0, last_res});
  endtask

  initial begin
    reset  = 1'b1;
    flush  = 1'b0;
    start  = 1'b0;
    alu_op = 5'd0;
    data1  = 32'd0;
    data2  = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;

    do_op(OpMul, 32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFA, MulLat, "mul");

    // Asynchronous reset in the middle of a divide
    @(negedge clock);
    launch(OpDiv, 32'd1000, 32'd7, "rst_div");
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_result", {32'd0, result}, 64'd0);
    last_res = 32'h0;
    @(negedge clock);
    reset = 1'b0;

    do_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, "mulhu");
    do_op(OpMulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat, "mulh");
    do_op(OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, "mulhsu");
    do_op(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div");
    do_op(OpRem, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem");
    do_op(OpDivu, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33, "divu");
    do_op(OpDiv, 32'h0000_000A, 32'h0, 32'hFFFF_FFFF, 1, "div_by0");
    do_op(OpRemu, 32'h0000_000A, 32'h0, 32'h0000_000A, 1, "remu_by0");
    do_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    do_op(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");

    // Non-M opcode is ignored
    @(negedge clock);
    start  = 1'b1;
    alu_op = OpLui;
    data1  = 32'd5;
    data2  = 32'd6;
    @(posedge clock);
    #1;
    start = 1'b0;
    quiet_window("lui", 40, 1'b1);

    // Start while busy is ignored; edges E1..E4 are consumed before wait_done
    @(negedge clock);
    exp_q.push_back(32'd14);
    launch(OpDivu, 32'd100, 32'd7, "busy_ign");
    repeat (4) @(negedge clock);
    start  = 1'b1;
    alu_op = OpDiv;
    data1  = 32'd1000;
    data2  = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("busy_ign", 29);
    quiet_window("busy_ign_after", 40, 1'b1);

    // Back-to-back: second start presented during the done cycle
    do_op(OpRemu, 32'd100, 32'd7, 32'd2, 33, "b2b_first");
    exp_q.push_back(32'd11);
    launch(OpDivu, 32'd100, 32'd9, "b2b_second");
    wait_done("b2b_second", 33);

    // Flush mid-divide leaves result untouched
    @(negedge clock);
    launch(OpDivu, 32'd1000, 32'd3, "flush_div");
    repeat (4) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    quiet_window("flush_after", 40, 1'b1);
    do_op(OpRemu, 32'd100, 32'd7, 32'd2, 33, "remu_post_flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
